// File: rtl/corrode_cell_grid_if.sv
// Pixel-in / cell-out bundle of the corrosion cell grid.
// The master side feeds binarised pixels and receives the per-cell keep/erode bits.
interface corrode_cell_grid_if;
  logic        i_valid;
  logic        i_sof;
  logic        i_bin;
  logic        o_valid;
  logic        o_wb;
  logic [12:0] o_cell_idx;
  logic        o_frame_done;

  modport master (
    output i_valid, i_sof, i_bin,
    input  o_valid, o_wb, o_cell_idx, o_frame_done
  );

  modport slave (
    input  i_valid, i_sof, i_bin,
    output o_valid, o_wb, o_cell_idx, o_frame_done
  );
endinterface

// File: rtl/corrode_cell_grid.sv
// Bins the in-window pixels of a raster stream into square cells, counts the
// foreground pixels per cell and emits one thresholded keep/erode bit per
// completed cell, in raster order of cells.
module corrode_cell_grid #(
  parameter int P_W    = 12,
  parameter int IMG_X  = 1280,
  parameter int IMG_Y  = 720,
  parameter int WIN_X1 = 320,
  parameter int WIN_Y1 = 40,
  parameter int CELL   = 8,
  parameter int C_L    = 80,
  parameter int C_R    = 80,
  parameter int THRESH = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  corrode_cell_grid_if.slave   bus
);

  localparam int PXW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int CXW = (C_L > 1) ? $clog2(C_L) : 1;
  localparam int CRW = (C_R > 1) ? $clog2(C_R) : 1;
  localparam int AW  = $clog2(CELL * CELL + 1);
  localparam int TW  = AW + 1;

  localparam logic [P_W-1:0] X_LO  = P_W'(WIN_X1);
  localparam logic [P_W-1:0] X_HI  = P_W'(WIN_X1 + C_L * CELL - 1);
  localparam logic [P_W-1:0] Y_LO  = P_W'(WIN_Y1);
  localparam logic [P_W-1:0] Y_HI  = P_W'(WIN_Y1 + C_R * CELL - 1);
  localparam logic [P_W-1:0] X_END = P_W'(IMG_X - 1);
  localparam logic [P_W-1:0] Y_END = P_W'(IMG_Y - 1);

  localparam logic [PXW-1:0] P_LAST  = PXW'(CELL - 1);
  localparam logic [CXW-1:0] CX_LAST = CXW'(C_L - 1);
  localparam logic [CRW-1:0] CR_LAST = CRW'(C_R - 1);
  localparam logic [TW-1:0]  THR     = TW'(THRESH);

  logic [P_W-1:0] cnt_x, cnt_y;
  logic [P_W-1:0] pos_x, pos_y;
  logic [PXW-1:0] px, py, px_e, py_e;
  logic [CXW-1:0] cx, cx_e;
  logic [CRW-1:0] cr, cr_e;
  logic [12:0]    emit_idx, emit_idx_e;

  logic [AW-1:0]  acc [C_L];
  logic [AW-1:0]  acc_cur;
  logic [TW-1:0]  total;

  logic sof_px, in_win;
  logic px_last, cx_last, py_last, cr_last;
  logic cell_start, cell_done, frame_last;

  // Effective position of the current pixel: a start-of-frame pixel is (0,0)
  // and restarts every sub-counter, so all later decisions use these views.
  always_comb begin
    sof_px     = bus.i_valid & bus.i_sof;
    pos_x      = sof_px ? '0 : cnt_x;
    pos_y      = sof_px ? '0 : cnt_y;
    px_e       = sof_px ? '0 : px;
    py_e       = sof_px ? '0 : py;
    cx_e       = sof_px ? '0 : cx;
    cr_e       = sof_px ? '0 : cr;
    emit_idx_e = sof_px ? '0 : emit_idx;

    in_win     = bus.i_valid &&
                 (pos_x >= X_LO) && (pos_x <= X_HI) &&
                 (pos_y >= Y_LO) && (pos_y <= Y_HI);

    px_last    = (px_e == P_LAST);
    py_last    = (py_e == P_LAST);
    cx_last    = (cx_e == CX_LAST);
    cr_last    = (cr_e == CR_LAST);
    cell_start = (px_e == '0) && (py_e == '0);
    cell_done  = in_win && px_last && py_last;
    frame_last = cr_last && cx_last;

    acc_cur    = acc[cx_e];
    total      = {1'b0, acc_cur} + TW'(bus.i_bin);
  end

  // Per-column accumulators; the first pixel of a cell overwrites, so no
  // clear is needed between cell-rows and reset can leave them alone.
  always_ff @(posedge sys_clk) begin
    if (in_win) begin
      if (cell_start) acc[cx_e] <= AW'(bus.i_bin);
      else            acc[cx_e] <= acc_cur + AW'(bus.i_bin);
    end
  end

  // Position tracking, cell sub-counters and the registered cell output.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_x            <= '0;
      cnt_y            <= '0;
      px               <= '0;
      py               <= '0;
      cx               <= '0;
      cr               <= '0;
      emit_idx         <= '0;
      bus.o_valid      <= 1'b0;
      bus.o_wb         <= 1'b0;
      bus.o_cell_idx   <= '0;
      bus.o_frame_done <= 1'b0;
    end else begin
      bus.o_valid      <= cell_done;
      bus.o_frame_done <= cell_done && frame_last;

      if (bus.i_valid) begin
        if (pos_x == X_END) begin
          cnt_x <= '0;
          cnt_y <= (pos_y == Y_END) ? '0 : pos_y + 1'b1;
        end else begin
          cnt_x <= pos_x + 1'b1;
          cnt_y <= pos_y;
        end

        px       <= px_e;
        py       <= py_e;
        cx       <= cx_e;
        cr       <= cr_e;
        emit_idx <= emit_idx_e;

        if (in_win) begin
          if (!px_last) begin
            px <= px_e + 1'b1;
          end else begin
            px <= '0;
            if (!cx_last) begin
              cx <= cx_e + 1'b1;
            end else begin
              cx <= '0;
              if (!py_last) begin
                py <= py_e + 1'b1;
              end else begin
                py <= '0;
                cr <= cr_last ? '0 : cr_e + 1'b1;
              end
            end
          end
        end

        // Cells finish in raster order, so a running count gives the index.
        if (cell_done) begin
          bus.o_wb       <= (total >= THR);
          bus.o_cell_idx <= emit_idx_e;
          emit_idx       <= frame_last ? '0 : emit_idx_e + 13'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_corrode_cell_grid.sv
// Directed bench for corrode_cell_grid on a reduced geometry: 24x20 image,
// window at (4,2), 4x4 cells, 4x3 cells per frame, threshold 8.
module tb_corrode_cell_grid;

  localparam int IMG_X  = 24;
  localparam int IMG_Y  = 20;
  localparam int WIN_X1 = 4;
  localparam int WIN_Y1 = 2;
  localparam int CELL   = 4;
  localparam int C_L    = 4;
  localparam int C_R    = 3;
  localparam int THRESH = 8;
  localparam int NPIX   = IMG_X * IMG_Y;
  localparam int NCELL  = C_L * C_R;

  logic sys_clk = 1'b0;
  logic sys_rst;

  always #5 sys_clk = ~sys_clk;

  corrode_cell_grid_if bus ();

  corrode_cell_grid #(
    .P_W(12), .IMG_X(IMG_X), .IMG_Y(IMG_Y), .WIN_X1(WIN_X1), .WIN_Y1(WIN_Y1),
    .CELL(CELL), .C_L(C_L), .C_R(C_R), .THRESH(THRESH)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  bit q_wb[$];
  int q_idx[$];
  bit q_done[$];
  bit q_lat[$];
  bit ref_wb[$];
  int ref_idx[$];

  // Image content for each stimulus mode.
  function automatic bit img(input int mode, input int x, input int y);
    int lx, ly, c, r, k;
    bit inw;
    lx  = x - WIN_X1;
    ly  = y - WIN_Y1;
    inw = (lx >= 0) && (lx < C_L * CELL) && (ly >= 0) && (ly < C_R * CELL);
    c   = lx / CELL;
    r   = ly / CELL;
    k   = (ly % CELL) * CELL + (lx % CELL);
    case (mode)
      0: return 1'b1;
      1: return !inw;
      2: begin
        if (!inw) return 1'b1;
        if (r == 0 && c == 0) return k < 8;
        if (r == 0 && c == 1) return k < 7;
        if (r == 0 && c == 2) return 1'b1;
        return ((x * 5 + y * 3) % 7) < 4;
      end
      default: return ((x * 3 + y) % 5) < 3;
    endcase
  endfunction

  function automatic bit is_comp(input int x, input int y);
    int lx, ly;
    lx = x - WIN_X1;
    ly = y - WIN_Y1;
    return (lx >= 0) && (lx < C_L * CELL) && (ly >= 0) && (ly < C_R * CELL) &&
           (lx % CELL == CELL - 1) && (ly % CELL == CELL - 1);
  endfunction

  function automatic bit exp_wb(input int mode, input int i);
    int r, c, sum;
    r   = i / C_L;
    c   = i % C_L;
    sum = 0;
    for (int yy = 0; yy < CELL; yy++)
      for (int xx = 0; xx < CELL; xx++)
        sum += int'(img(mode, WIN_X1 + c * CELL + xx, WIN_Y1 + r * CELL + yy));
    return sum >= THRESH;
  endfunction

  task automatic clear_q();
    q_wb.delete();
    q_idx.delete();
    q_done.delete();
    q_lat.delete();
  endtask

  // One clock: drive inputs, take the edge, record any pulse together with
  // whether the pixel sampled at that same edge was a cell-completing one.
  task automatic tick(input logic v, input logic s, input logic b, input bit comp);
    bus.i_valid = v;
    bus.i_sof   = s;
    bus.i_bin   = b;
    @(posedge sys_clk);
    #1;
    if (bus.o_valid === 1'b1) begin
      q_wb.push_back(bus.o_wb);
      q_idx.push_back(int'(bus.o_cell_idx));
      q_done.push_back(bus.o_frame_done);
      q_lat.push_back(comp);
    end
  endtask

  task automatic drive(input int mode, input int p0, input int p1, input bit use_sof,
                       input int max_gap);
    int x, y;
    for (int p = p0; p <= p1; p++) begin
      x = p % IMG_X;
      y = p / IMG_X;
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, use_sof && (p == 0), img(mode, x, y), is_comp(x, y));
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_wb !== 1'b0) begin n_err++; $display("FAIL reset_wb: got %b want 0", bus.o_wb); end
    n_vec++; if (bus.o_cell_idx !== 13'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", bus.o_cell_idx); end
    n_vec++; if (bus.o_frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.o_frame_done); end
    sys_rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    clear_q();
  endtask

  task automatic test_all_ones();
    clear_q();
    drive(0, 0, NPIX - 1, 1'b1, 0);
    n_vec++; if (q_wb.size() != NCELL) begin n_err++; $display("FAIL ones_count: got %0d want %0d", q_wb.size(), NCELL); end
    for (int i = 0; i < q_wb.size(); i++) begin
      n_vec++; if (q_wb[i] !== 1'b1) begin n_err++; $display("FAIL ones_wb[%0d]: got %b want 1", i, q_wb[i]); end
      n_vec++; if (q_idx[i] != i) begin n_err++; $display("FAIL ones_idx[%0d]: got %0d want %0d", i, q_idx[i], i); end
      n_vec++; if (q_done[i] !== (i == NCELL - 1)) begin n_err++; $display("FAIL ones_done[%0d]: got %b want %b", i, q_done[i], i == NCELL - 1); end
      n_vec++; if (q_lat[i] !== 1'b1) begin n_err++; $display("FAIL ones_latency[%0d]: pulse not 1 cycle after completing pixel", i); end
    end
  endtask

  task automatic test_all_zeros();
    clear_q();
    drive(1, 0, NPIX - 1, 1'b1, 0);
    n_vec++; if (q_wb.size() != NCELL) begin n_err++; $display("FAIL zeros_count: got %0d want %0d", q_wb.size(), NCELL); end
    for (int i = 0; i < q_wb.size(); i++) begin
      n_vec++; if (q_wb[i] !== 1'b0) begin n_err++; $display("FAIL zeros_wb[%0d]: got %b want 0", i, q_wb[i]); end
      n_vec++; if (q_idx[i] != i) begin n_err++; $display("FAIL zeros_idx[%0d]: got %0d want %0d", i, q_idx[i], i); end
    end
  endtask

  task automatic test_threshold();
    clear_q();
    drive(2, 0, NPIX - 1, 1'b1, 0);
    n_vec++; if (q_wb.size() != NCELL) begin n_err++; $display("FAIL thr_count: got %0d want %0d", q_wb.size(), NCELL); end
    if (q_wb.size() >= 3) begin
      n_vec++; if (q_wb[0] !== 1'b1) begin n_err++; $display("FAIL thr_exact: got %b want 1", q_wb[0]); end
      n_vec++; if (q_wb[1] !== 1'b0) begin n_err++; $display("FAIL thr_below: got %b want 0", q_wb[1]); end
      n_vec++; if (q_wb[2] !== 1'b1) begin n_err++; $display("FAIL thr_full: got %b want 1", q_wb[2]); end
    end
    for (int i = 0; i < q_wb.size(); i++) begin
      n_vec++; if (q_wb[i] !== exp_wb(2, i)) begin n_err++; $display("FAIL thr_wb[%0d]: got %b want %b", i, q_wb[i], exp_wb(2, i)); end
      n_vec++; if (q_idx[i] != i) begin n_err++; $display("FAIL thr_idx[%0d]: got %0d want %0d", i, q_idx[i], i); end
    end
    ref_wb  = q_wb;
    ref_idx = q_idx;
  endtask

  task automatic test_gaps();
    clear_q();
    drive(2, 0, NPIX - 1, 1'b1, 5);
    n_vec++; if (q_wb.size() != ref_wb.size()) begin n_err++; $display("FAIL gap_count: got %0d want %0d", q_wb.size(), ref_wb.size()); end
    for (int i = 0; i < q_wb.size() && i < ref_wb.size(); i++) begin
      n_vec++; if (q_wb[i] !== ref_wb[i]) begin n_err++; $display("FAIL gap_wb[%0d]: got %b want %b", i, q_wb[i], ref_wb[i]); end
      n_vec++; if (q_idx[i] != ref_idx[i]) begin n_err++; $display("FAIL gap_idx[%0d]: got %0d want %0d", i, q_idx[i], ref_idx[i]); end
      n_vec++; if (q_lat[i] !== 1'b1) begin n_err++; $display("FAIL gap_latency[%0d]: pulse not 1 cycle after completing pixel", i); end
    end
  endtask

  task automatic test_sof_mid_frame();
    // Stop inside cell-row 1, line 2 of the cell-row; only cell-row 0 completed.
    clear_q();
    drive(0, 0, (WIN_Y1 + CELL + 2) * IMG_X + WIN_X1 + 5, 1'b1, 0);
    n_vec++; if (q_wb.size() != C_L) begin n_err++; $display("FAIL sof_partial_count: got %0d want %0d", q_wb.size(), C_L); end
    clear_q();
    drive(3, 0, NPIX - 1, 1'b1, 0);
    n_vec++; if (q_wb.size() != NCELL) begin n_err++; $display("FAIL sof_count: got %0d want %0d", q_wb.size(), NCELL); end
    for (int i = 0; i < q_wb.size(); i++) begin
      n_vec++; if (q_wb[i] !== exp_wb(3, i)) begin n_err++; $display("FAIL sof_wb[%0d]: got %b want %b", i, q_wb[i], exp_wb(3, i)); end
      n_vec++; if (q_idx[i] != i) begin n_err++; $display("FAIL sof_idx[%0d]: got %0d want %0d", i, q_idx[i], i); end
      n_vec++; if (q_done[i] !== (i == NCELL - 1)) begin n_err++; $display("FAIL sof_done[%0d]: got %b want %b", i, q_done[i], i == NCELL - 1); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int pr;
    // Reset coincides with the completing pixel of cell (2,0).
    pr = (WIN_Y1 + 3 * CELL - 1) * IMG_X + WIN_X1 + CELL - 1;
    clear_q();
    drive(0, 0, pr - 1, 1'b1, 0);
    sys_rst = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    sys_rst = 1'b0;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_wb !== 1'b0) begin n_err++; $display("FAIL rstmid_wb: got %b want 0", bus.o_wb); end
    n_vec++; if (bus.o_cell_idx !== 13'd0) begin n_err++; $display("FAIL rstmid_idx: got %0d want 0", bus.o_cell_idx); end
    n_vec++; if (bus.o_frame_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", bus.o_frame_done); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    // Fresh frame without i_sof: first valid pixel after reset is (0,0).
    clear_q();
    drive(2, 0, NPIX - 1, 1'b0, 0);
    n_vec++; if (q_wb.size() != NCELL) begin n_err++; $display("FAIL rstmid_count: got %0d want %0d", q_wb.size(), NCELL); end
    for (int i = 0; i < q_wb.size(); i++) begin
      n_vec++; if (q_wb[i] !== exp_wb(2, i)) begin n_err++; $display("FAIL rstmid_wb[%0d]: got %b want %b", i, q_wb[i], exp_wb(2, i)); end
      n_vec++; if (q_idx[i] != i) begin n_err++; $display("FAIL rstmid_idx[%0d]: got %0d want %0d", i, q_idx[i], i); end
      n_vec++; if (q_lat[i] !== 1'b1) begin n_err++; $display("FAIL rstmid_latency[%0d]: pulse not 1 cycle after completing pixel", i); end
    end
  endtask

  initial begin
    sys_rst     = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_bin   = 1'b0;
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_threshold();
    test_gaps();
    test_sof_mid_frame();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
